// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit_pkg
//  Description : Shared encodings for the hazard/forwarding controller:
//                operand forward selects and load-use stall FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_forward_unit_pkg;

  // Operand source selects driven to the EX stage operand muxes
  localparam logic [1:0] FWD_REGFILE = 2'b00;  // value read from register file
  localparam logic [1:0] FWD_WB      = 2'b01;  // value being written back (MEM/WB)
  localparam logic [1:0] FWD_EXMEM   = 2'b10;  // ALU result held in EX/MEM

  // Default widths
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int CNT_WIDTH_DEF      = 16;

  // Load-use stall FSM
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hfu_state_e;

endpackage : hazard_forward_unit_pkg
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Per-operand forwarding priority comparator. The youngest
//                in-flight producer (EX/MEM) wins over the older one (MEM/WB);
//                register x0 is hard-wired zero and is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
  input  logic                      exm_wr_i,
  input  logic [REG_ADDR_WIDTH-1:0] mwb_rd_i,
  input  logic                      mwb_wr_i,
  output logic [1:0]                sel_o
);

  logic w_exm_hit;
  logic w_mwb_hit;

  // A stage supplies the operand only if it writes a non-zero rd equal to rs
  assign w_exm_hit = exm_wr_i && (exm_rd_i != '0) && (exm_rd_i == rs_i);
  assign w_mwb_hit = mwb_wr_i && (mwb_rd_i != '0) && (mwb_rd_i == rs_i);

  // Priority select: EX/MEM first, then MEM/WB, else the register file
  always_comb begin
    sel_o = FWD_REGFILE;
    if (w_exm_hit) begin
      sel_o = FWD_EXMEM;
    end else if (w_mwb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit
//  Description : Hazard and forwarding controller for the 5-stage RISC-V
//                pipeline. Shadows the EX/MEM and MEM/WB destination state,
//                drives forwardA/forwardB, detects load-use hazards, runs the
//                one-cycle stall FSM, converts a taken branch into IF/ID flush
//                plus ID/EX bubble, and counts stall cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      ID_EX_reg_write,
  input  logic                      ID_EX_mem_read,
  input  logic                      branch_taken,
  output logic [1:0]                forwardA,
  output logic [1:0]                forwardB,
  output logic                      pc_write,
  output logic                      IF_ID_write,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_bubble,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  // --------------------------------------------------------------------------
  // Shadow copies of the downstream pipeline registers' destination fields
  // --------------------------------------------------------------------------
  logic [REG_ADDR_WIDTH-1:0] exm_rd_q;
  logic                      exm_wr_q;
  logic                      exm_ld_q;
  logic [REG_ADDR_WIDTH-1:0] mwb_rd_q;
  logic                      mwb_wr_q;

  hfu_state_e                state_q;
  hfu_state_e                state_d;
  logic [CNT_WIDTH-1:0]      stall_count_q;
  logic [CNT_WIDTH-1:0]      stall_count_d;

  logic                      w_hz;
  logic                      w_stall;

  // EX always advances, so both shadows shift unconditionally every cycle;
  // a bubble shows up here simply as reg_write=0 on the ID_EX inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exm_rd_q <= '0;
      exm_wr_q <= 1'b0;
      exm_ld_q <= 1'b0;
      mwb_rd_q <= '0;
      mwb_wr_q <= 1'b0;
    end else begin
      exm_rd_q <= ID_EX_rd;
      exm_wr_q <= ID_EX_reg_write;
      exm_ld_q <= ID_EX_mem_read;
      mwb_rd_q <= exm_rd_q;
      mwb_wr_q <= exm_wr_q;
    end
  end

  // --------------------------------------------------------------------------
  // Operand forwarding, one comparator per EX source operand
  // --------------------------------------------------------------------------
  fwd_sel #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_a (
    .rs_i     (ID_EX_rs1),
    .exm_rd_i (exm_rd_q),
    .exm_wr_i (exm_wr_q),
    .mwb_rd_i (mwb_rd_q),
    .mwb_wr_i (mwb_wr_q),
    .sel_o    (forwardA)
  );

  fwd_sel #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_b (
    .rs_i     (ID_EX_rs2),
    .exm_rd_i (exm_rd_q),
    .exm_wr_i (exm_wr_q),
    .mwb_rd_i (mwb_rd_q),
    .mwb_wr_i (mwb_wr_q),
    .sel_o    (forwardB)
  );

  // --------------------------------------------------------------------------
  // Load-use hazard: load in EX whose rd feeds the instruction sitting in ID
  // --------------------------------------------------------------------------
  assign w_hz = ID_EX_mem_read && (ID_EX_rd != '0) &&
                ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

  // State register for the one-cycle stall FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and pipeline controls; a taken branch overrides any stall
  always_comb begin
    state_d      = ST_RUN;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    w_stall      = 1'b0;

    if (branch_taken) begin
      // Wrong-path instruction in IF/ID is squashed; the one in ID/EX is
      // replaced by a bubble. PC takes the branch target.
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      state_d      = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_hz) begin
            w_stall      = 1'b1;
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            state_d      = ST_STALL;
          end
        end
        ST_STALL: begin
          // ID/EX now holds the bubble, so no second stall is possible
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating count of load-use stall cycles
  // --------------------------------------------------------------------------
  always_comb begin
    stall_count_d = stall_count_q;
    if (w_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

  // A load's data does not exist in EX/MEM yet, so it must never be selected
  a_no_exmem_from_load : assert property (
    @(posedge clk) disable iff (!reset_n)
      !(exm_ld_q && ((forwardA == FWD_EXMEM) || (forwardB == FWD_EXMEM)))
  );

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_unit
//  Description : Self-checking bench for hazard_forward_unit: a table of
//                hand-derived per-cycle vectors, hand-written reset and
//                saturation sequences, and randomized traffic compared with
//                a reference model of the forwarding/stall rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

  logic       clk;
  logic       reset_n;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic       ID_EX_reg_write, ID_EX_mem_read, branch_taken;

  logic [1:0]  forwardA, forwardB;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic [15:0] stall_count;

  logic [1:0]  s_forwardA, s_forwardB;
  logic        s_pc_write, s_IF_ID_write, s_IF_ID_flush, s_ID_EX_bubble;
  logic [1:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit dut (
    .clk(clk), .reset_n(reset_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .branch_taken(branch_taken),
    .forwardA(forwardA), .forwardB(forwardB), .pc_write(pc_write),
    .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .stall_count(stall_count)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles
  hazard_forward_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .branch_taken(branch_taken),
    .forwardA(s_forwardA), .forwardB(s_forwardB), .pc_write(s_pc_write),
    .IF_ID_write(s_IF_ID_write), .IF_ID_flush(s_IF_ID_flush),
    .ID_EX_bubble(s_ID_EX_bubble), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] = instruction that was in EX one cycle ago, hist[1] = two ago
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } prod_t;

  prod_t m_hist [0:1];
  bit    m_stalled_last;
  int    m_cnt;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    for (int a = 0; a < 2; a++) begin
      if (m_hist[a].wr && m_hist[a].rd != 0 && m_hist[a].rd == rs)
        return (a == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit ref_stall();
    bit hz;
    hz = ID_EX_mem_read && ID_EX_rd != 0 &&
         (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
    return hz && !branch_taken && !m_stalled_last;
  endfunction

  // {forwardA, forwardB, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble}
  function automatic logic [7:0] ref_ctl();
    bit st;
    st = ref_stall();
    return {ref_fwd(ID_EX_rs1), ref_fwd(ID_EX_rs2), !st, !st,
            branch_taken, branch_taken | st};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_hist[0] = '0;
    m_hist[1] = '0;
    m_stalled_last = 1'b0;
    m_cnt = 0;
  endtask

  // Called right after a rising edge, while the sampled inputs are still held
  task automatic model_update();
    bit st;
    st = ref_stall();
    m_hist[1] = m_hist[0];
    m_hist[0] = '{rd: ID_EX_rd, wr: ID_EX_reg_write, ld: ID_EX_mem_read};
    m_stalled_last = st;
    if (st) m_cnt++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_ctl();
    return {forwardA, forwardB, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble};
  endfunction

  task automatic set_in(input int ir1, ir2, er1, er2, erd,
                        input bit wr, ld, br);
    IF_ID_rs1 = 5'(ir1); IF_ID_rs2 = 5'(ir2);
    ID_EX_rs1 = 5'(er1); ID_EX_rs2 = 5'(er2); ID_EX_rd = 5'(erd);
    ID_EX_reg_write = wr; ID_EX_mem_read = ld; branch_taken = br;
  endtask

  // Compare both instances with the model mid-cycle, then advance one clock
  task automatic run_cycle(input string name);
    @(negedge clk);
    chk({name, "_ctl"}, 32'(dut_ctl()), 32'(ref_ctl()));
    chk({name, "_cnt"}, 32'(stall_count), 32'(sat(m_cnt, 65535)));
    chk({name, "_satcnt"}, 32'(s_stall_count), 32'(sat(m_cnt, 3)));
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; reset values checked while held
  task automatic do_reset(input string name);
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #2;
    chk({name, "_ctl"}, 32'(dut_ctl()), 32'(8'b00_00_1_1_0_0));
    chk({name, "_cnt"}, 32'(stall_count), 32'd0);
    chk({name, "_satcnt"}, 32'(s_stall_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [4:0]  ir1, ir2, er1, er2, erd;
    logic        wr, ld, br;
    logic [7:0]  ectl;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [0:14];

  function automatic vec_t mk(input int ir1, ir2, er1, er2, erd,
                              input bit wr, ld, br,
                              input logic [7:0] ectl, input int ecnt);
    return '{ir1: 5'(ir1), ir2: 5'(ir2), er1: 5'(er1), er2: 5'(er2),
             erd: 5'(erd), wr: wr, ld: ld, br: br,
             ectl: ectl, ecnt: 16'(ecnt)};
  endfunction

  initial begin
    //            IF rs1,rs2 EX rs1,rs2,rd  wr ld br   fA fB pc ifw fl bub  cnt
    tbl[0]  = mk(0, 0,  1, 2, 5,  1, 0, 0, 8'b00_00_1_1_0_0, 0); // add x5
    tbl[1]  = mk(0, 0,  5, 1, 6,  1, 0, 0, 8'b10_00_1_1_0_0, 0); // sub x6,x5,x1
    tbl[2]  = mk(0, 0,  6, 5, 7,  1, 0, 0, 8'b10_01_1_1_0_0, 0); // both stages
    tbl[3]  = mk(0, 0,  0, 7, 7,  1, 0, 0, 8'b00_10_1_1_0_0, 0);
    tbl[4]  = mk(0, 0,  7, 7, 7,  0, 0, 0, 8'b10_10_1_1_0_0, 0); // rd7 both: EX/MEM wins
    tbl[5]  = mk(0, 0,  9, 7, 0,  1, 0, 0, 8'b00_01_1_1_0_0, 0); // exm_wr=0 -> WB
    tbl[6]  = mk(0, 0,  0, 0, 0,  1, 0, 0, 8'b00_00_1_1_0_0, 0);
    tbl[7]  = mk(0, 0,  0, 0, 0,  1, 0, 0, 8'b00_00_1_1_0_0, 0); // x0 in both stages
    tbl[8]  = mk(4, 3,  0, 0, 3,  1, 1, 0, 8'b00_00_0_0_0_1, 0); // lw x3, ID uses x3
    tbl[9]  = mk(4, 3,  0, 0, 0,  0, 0, 0, 8'b00_00_1_1_0_0, 1); // bubble, STALL
    tbl[10] = mk(0, 0,  4, 3, 8,  1, 0, 0, 8'b00_01_1_1_0_0, 1); // consumer gets WB
    tbl[11] = mk(9, 0,  0, 0, 9,  1, 1, 1, 8'b00_00_1_1_1_1, 1); // hz + branch
    tbl[12] = mk(0, 0,  0, 0, 0,  0, 0, 0, 8'b00_00_1_1_0_0, 1);
    tbl[13] = mk(10, 0, 0, 0, 10, 1, 1, 0, 8'b00_00_0_0_0_1, 1); // RUN after flush
    tbl[14] = mk(0, 0,  0, 0, 0,  0, 0, 0, 8'b00_00_1_1_0_0, 2);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset("reset");

    // Directed table
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].ir1, tbl[i].ir2, tbl[i].er1, tbl[i].er2, tbl[i].erd,
             tbl[i].wr, tbl[i].ld, tbl[i].br);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(dut_ctl()), 32'(tbl[i].ectl));
      chk($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(tbl[i].ecnt));
      @(posedge clk);
      model_update();
      #1;
    end

    // Reset while in STALL: next cycle must be RUN with counters cleared
    set_in(0, 11, 0, 0, 11, 1, 1, 0);
    run_cycle("pre_rst_stall");
    do_reset("rst_in_stall");
    set_in(12, 0, 0, 0, 12, 1, 1, 0);
    @(negedge clk);
    chk("post_rst_run_pcw", 32'(pc_write), 32'd0);
    chk("post_rst_cnt", 32'(stall_count), 32'd0);
    @(posedge clk);
    model_update();
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("post_rst_stall");

    // Saturation of the narrow counter: more stalls than it can count
    for (int k = 0; k < 5; k++) begin
      set_in(13, 0, 0, 0, 13, 1, 1, 0);
      run_cycle($sformatf("sat_hz%0d", k));
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      run_cycle($sformatf("sat_q%0d", k));
    end
    @(negedge clk);
    chk("sat_hold", 32'(s_stall_count), 32'd3);
    @(posedge clk);
    model_update();
    #1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int  rd, er1, er2;
      bit  ld, wr, br;
      if (($urandom % 97) == 0) begin
        do_reset($sformatf("rnd_rst%0d", n));
      end
      ld  = ($urandom % 3) == 0;
      wr  = ld ? 1'b1 : 1'($urandom % 2);
      br  = ($urandom % 8) == 0;
      rd  = int'($urandom_range(0, 7));
      er1 = int'($urandom_range(0, 7));
      er2 = int'($urandom_range(0, 7));
      // A real pipeline never has a load's consumer directly behind it in EX
      if (m_hist[0].ld && m_hist[0].rd != 0) begin
        if (er1 == int'(m_hist[0].rd)) er1 = 0;
        if (er2 == int'(m_hist[0].rd)) er2 = 0;
      end
      set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             er1, er2, rd, wr, ld, br);
      run_cycle($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_forward_unit
`default_nettype wire

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Hazard and forwarding controller for the 5-stage RISC-V pipeline. It tracks the destination-register state of the EX/MEM and MEM/WB stages in internal shadow registers. From these it drives the 2-bit `forwardA`/`forwardB` selects consumed by `stage_EX`. It also detects load-use hazards, runs the one-cycle stall FSM, and converts a taken branch/jump into IF/ID flush and ID/EX bubble controls. A saturating stall counter is provided for performance debug.

## Interface
- `REG_ADDR_WIDTH`, 5: register index width.
- `CNT_WIDTH`, 16: stall counter width.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IF_ID_rs1`, `IF_ID_rs2`  in  REG_ADDR_WIDTH  source regs of the instruction in ID.
- `ID_EX_rs1`, `ID_EX_rs2`  in  REG_ADDR_WIDTH  source regs of the instruction in EX.
- `ID_EX_rd`  in  REG_ADDR_WIDTH  destination of the instruction in EX.
- `ID_EX_reg_write`  in  1  EX instruction writes rd.
- `ID_EX_mem_read`  in  1  EX instruction is a load.
- `branch_taken`  in  1  EX resolved a taken branch/jump this cycle.
- `forwardA`, `forwardB`  out  2  operand source select for EX.
- `pc_write`  out  1  PC may update.
- `IF_ID_write`  out  1  IF/ID may update.
- `IF_ID_flush`  out  1  clear IF/ID to NOP.
- `ID_EX_bubble`  out  1  load NOP into ID/EX.
- `stall_count`  out  CNT_WIDTH  number of load-use stall cycles, saturating.

## Operation
- Shadow regs: `exm_rd`, `exm_wr`, `exm_ld`, `mwb_rd`, `mwb_wr`.
  - Every cycle: exm ← {ID_EX_rd, ID_EX_reg_write, ID_EX_mem_read}; mwb ← {exm_rd, exm_wr}.
  - EX always advances. A bubble arrives in ID_EX the cycle after `ID_EX_bubble`, with reg_write=0.
- Forward select, per operand X with source ID_EX_rsX:
  - `2'b10` (EX_MEM_alu_out) if exm_wr && exm_rd != 0 && exm_rd == rsX.
  - else `2'b01` (WB_data) if mwb_wr && mwb_rd != 0 && mwb_rd == rsX.
  - else `2'b00` (register file). `2'b11` is never driven.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Load-use hazard: `hz` = ID_EX_mem_read && ID_EX_rd != 0 && (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2).
- FSM states:
  - RUN: on hz && !branch_taken, assert the stall (pc_write=0, IF_ID_write=0, ID_EX_bubble=1) and go to STALL. Otherwise stay in RUN.
  - STALL: outputs normal; return to RUN unconditionally. A back-to-back stall cannot occur here because ID_EX now holds a bubble.
- Flush: branch_taken → IF_ID_flush=1 and ID_EX_bubble=1, pc_write=1, in any state. Flush overrides hz, so no stall is taken and stall_count is unchanged. The FSM goes to RUN.
- stall_count increments on every cycle that asserts the load-use stall and holds at all-ones.
- Invariant, assertion only: never forwardX==`2'b10` while exm_ld=1.

## Timing
- forwardA/B, pc_write, IF_ID_write, IF_ID_flush and ID_EX_bubble are combinational from inputs and state in the same cycle. They do not depend on the ALU datapath.
- A stall costs exactly 1 cycle. The dependent instruction then gets `2'b01` from the load via MEM/WB.
- Reset values:
  - Shadow regs: rd=0, wr=0, ld=0.
  - State: RUN. stall_count=0.
  - Outputs: forwardA/B=00, pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0 (given quiet inputs).
- Reset asserted mid-stall returns to RUN immediately and clears the shadow regs.

## Structure
- Add to `risc_v_defines.vh`: `FWD_REGFILE`=2'b00, `FWD_WB`=2'b01, `FWD_EXMEM`=2'b10, `REG_ADDR_WIDTH`, FSM state encodings RUN/STALL.
- One sub-module, `fwd_sel`: a per-operand priority comparator. Inputs rs, exm_rd/wr, mwb_rd/wr; output the 2-bit select. Instantiated twice, for A and B.

## Test plan
- `add x5`, then `sub x6,x5,x1` in EX: exm_rd=5, exm_wr=1, ID_EX_rs1=5 → forwardA=10, forwardB=00.
- Same rd in both stages: exm_rd=mwb_rd=7, rs2=7 → forwardB=10. With exm_wr=0 → forwardB=01.
- rd=x0 writes in both stages, rs1=0 → forwardA=00.
- `lw x3` in EX, IF_ID_rs2=3:
  - Cycle 0: pc_write=0, IF_ID_write=0, ID_EX_bubble=1.
  - Cycle 1: STALL state, no stall.
  - Cycle 2: forwardB=01.
  - stall_count=1 afterwards.
- Load-use hazard with branch_taken=1 in the same cycle → IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, stall_count unchanged.
- Drive reset_n low during STALL → next cycle is RUN, all outputs at reset values, stall_count=0.
- Force the counter to all-ones, then another stall → stall_count stays all-ones.
